aes_spi_arbiter: RTL
====================

Name: aes_spi_arbiter

Overview:
- Shares one serial MOSI link between two AES SPI slaves: cipher, selected by cs_enc_n, and inverse cipher, selected by cs_dec_n.
- Two requesters (encrypt port, decrypt port) each hold a level request.
- A round-robin arbiter grants one requester at a time. The block then serialises the block and key, waits a turnaround gap, shifts in 128 result bits from the selected slave, and pulses a per-requester done.

Parameters:
- DATA_W, 128: block width in bits; frame data and result field length.
- KEY_W, 256: key bus width.
- GAP, 4: turnaround cycles between the last key bit and the first result sample (MOSI held 0).

Ports:
- clk  in  1  single system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_enc  in  1  level request from encrypt requester.
- req_dec  in  1  level request from decrypt requester.
- enc_data  in  DATA_W  plaintext; latched at grant.
- dec_data  in  DATA_W  ciphertext; latched at grant.
- key  in  KEY_W  shared key; latched at grant.
- nk_val  in  2  00=Nk4, 01=Nk6, 10/11=Nk8; latched at grant.
- miso_enc  in  1  serial result from cipher slave.
- miso_dec  in  1  serial result from inverse-cipher slave.
- gnt_enc  out  1  one-cycle pulse: encrypt request accepted.
- gnt_dec  out  1  one-cycle pulse: decrypt request accepted.
- busy  out  1  high from grant until the done pulse inclusive.
- mosi  out  1  registered serial output.
- cs_enc_n  out  1  active-low select of cipher slave.
- cs_dec_n  out  1  active-low select of inverse-cipher slave.
- result  out  DATA_W  last completed result; holds until the next done.
- done_enc  out  1  one-cycle pulse: result valid for an encrypt job.
- done_dec  out  1  one-cycle pulse: result valid for a decrypt job.

Behaviour:
- Reset, asynchronous, any state including mid-frame, forces:
  - state IDLE;
  - mosi=0, cs_enc_n=1, cs_dec_n=1;
  - result=0;
  - gnt_*=0, done_*=0, busy=0;
  - round-robin pointer = "enc has priority".
- An aborted frame produces no done and no result change.
- States: IDLE -> SEND_DATA -> SEND_KEY -> GAP -> RECV -> DONE -> IDLE.
- IDLE:
  - No request: outputs idle and pointer unchanged.
  - Exactly one request: that requester is granted.
  - Both requests: granted per pointer; the pointer then flips to favour the other requester.
- Grant edge E0 (leaving IDLE), all in the same edge:
  - gnt_x=1 for one cycle; busy=1.
  - The selected cs_*_n goes low; the other stays high.
  - data, key and Nk (Nk=4/6/8) are latched.
  - mosi = latched data[DATA_W-1].
- Bit counter per field, sent MSB first:
  - SEND_DATA: edges E0..E127 drive data[127..0].
  - SEND_KEY: edges E128..E(127+32Nk) drive key[255] down to key[256-32Nk]. Lower key bits are never sent.
  - GAP: next GAP edges drive mosi=0.
  - RECV: mosi=0. On each of the next 128 edges, result_shift <= {result_shift[126:0], miso_sel}, where miso_sel is the selected slave's MISO. The first sampled bit ends in bit 127.
- DONE at edge EN, N = 256 + 32*Nk + GAP (Nk4/GAP4: N=388):
  - result <= result_shift; done_x=1 for one cycle.
  - cs_*_n=1; busy=0 the following cycle; state IDLE.
- A new grant is possible no earlier than edge EN+1.
- Requests are sampled only in IDLE. A request held through a busy period is served after it and is not lost.
- A request deasserting after grant does not abort the frame.
- Input changes after grant (data, key, nk_val) do not affect the frame in flight.
- gnt and done for the same requester never coincide. Both cs_*_n are never low simultaneously.

Test Plan:
- Reset, then req_enc=1, Nk4, enc_data=00112233445566778899aabbccddeeff:
  - mosi reproduces the 128 data bits then key[255:128], then 4 zeros;
  - cs_enc_n low edges E0..E387; done_enc at E388.
- Same job with miso_enc driven from 69c4e0d86a7b0430d8cdb78070b4c55a MSB first during RECV: result equals that value at done_enc, and holds afterwards.
- req_enc and req_dec both held from reset: grants in order enc, dec, enc, with each done preceding the next grant; cs_dec_n low only during dec frames.
- Nk6 and Nk8 decrypt jobs: done_dec at E452 and E516; the key field covers exactly 192 and 256 bits.
- rst pulsed at E200 of a frame: outputs immediately idle, no done, result stays 0, and a new request is granted normally.
- enc_data and key changed mid-frame: transmitted bits match the values latched at E0.

Source files
------------

// File: rtl/aes_spi_arbiter.sv
// rtl/aes_spi_arbiter.sv - round-robin arbiter sharing one MOSI link between AES cipher and inverse-cipher slaves
// Serialises block then key (MSB first), idles a turnaround gap, then shifts in a 128-bit result.
module aes_spi_arbiter #(
  parameter int DATA_W = 128,
  parameter int KEY_W  = 256,
  parameter int GAP    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_enc,
  input  logic              req_dec,
  input  logic [DATA_W-1:0] enc_data,
  input  logic [DATA_W-1:0] dec_data,
  input  logic [KEY_W-1:0]  key,
  input  logic [1:0]        nk_val,
  input  logic              miso_enc,
  input  logic              miso_dec,
  output logic              gnt_enc,
  output logic              gnt_dec,
  output logic              busy,
  output logic              mosi,
  output logic              cs_enc_n,
  output logic              cs_dec_n,
  output logic [DATA_W-1:0] result,
  output logic              done_enc,
  output logic              done_dec
);

  localparam int CNT_W = $clog2(DATA_W + KEY_W + GAP + 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_KEY, S_GAP, S_RECV, S_DONE} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [CNT_W-1:0]   key_bits, key_bits_d;
  logic [DATA_W-1:0]  data_sr, data_sr_d;
  logic [KEY_W-1:0]   key_sr, key_sr_d;
  logic [DATA_W-1:0]  rx_sr, rx_sr_d;
  logic               sel_dec, sel_dec_d;
  logic               prio_dec, prio_dec_d;
  logic [DATA_W-1:0]  result_d;
  logic               mosi_d, cs_enc_n_d, cs_dec_n_d, busy_d;
  logic               gnt_enc_d, gnt_dec_d, done_enc_d, done_dec_d;

  logic               pick_dec;
  logic               miso_sel;
  logic [DATA_W-1:0]  frame_data;
  logic [CNT_W-1:0]   nk_bits;

  // Decrypt wins only when alone or when the pointer favours it.
  assign pick_dec   = req_dec & (~req_enc | prio_dec);
  assign frame_data = pick_dec ? dec_data : enc_data;
  assign miso_sel   = sel_dec ? miso_dec : miso_enc;

  always_comb begin
    case (nk_val)
      2'b00:   nk_bits = CNT_W'(32 * 4);
      2'b01:   nk_bits = CNT_W'(32 * 6);
      default: nk_bits = CNT_W'(32 * 8);
    endcase
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    key_bits_d = key_bits;
    data_sr_d  = data_sr;
    key_sr_d   = key_sr;
    rx_sr_d    = rx_sr;
    sel_dec_d  = sel_dec;
    prio_dec_d = prio_dec;
    result_d   = result;
    mosi_d     = 1'b0;
    cs_enc_n_d = cs_enc_n;
    cs_dec_n_d = cs_dec_n;
    busy_d     = busy;
    gnt_enc_d  = 1'b0;
    gnt_dec_d  = 1'b0;
    done_enc_d = 1'b0;
    done_dec_d = 1'b0;

    case (state)
      S_IDLE: begin
        busy_d     = 1'b0;
        cs_enc_n_d = 1'b1;
        cs_dec_n_d = 1'b1;
        if (req_enc || req_dec) begin
          if (req_enc && req_dec) prio_dec_d = ~prio_dec;
          sel_dec_d  = pick_dec;
          gnt_enc_d  = ~pick_dec;
          gnt_dec_d  = pick_dec;
          cs_enc_n_d = pick_dec;
          cs_dec_n_d = ~pick_dec;
          busy_d     = 1'b1;
          mosi_d     = frame_data[DATA_W-1];
          data_sr_d  = frame_data << 1;
          key_sr_d   = key;
          key_bits_d = nk_bits;
          cnt_d      = CNT_W'(1);
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        mosi_d    = data_sr[DATA_W-1];
        data_sr_d = data_sr << 1;
        cnt_d     = cnt + 1'b1;
        if (cnt == DATA_LAST) begin
          cnt_d   = '0;
          state_d = S_KEY;
        end
      end
      S_KEY: begin
        mosi_d   = key_sr[KEY_W-1];
        key_sr_d = key_sr << 1;
        cnt_d    = cnt + 1'b1;
        if (cnt == key_bits - 1'b1) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        cnt_d = cnt + 1'b1;
        if (cnt == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        rx_sr_d = {rx_sr[DATA_W-2:0], miso_sel};
        cnt_d   = cnt + 1'b1;
        if (cnt == DATA_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // busy stays high through the done cycle and drops on the next IDLE edge
        result_d   = rx_sr;
        done_enc_d = ~sel_dec;
        done_dec_d = sel_dec;
        cs_enc_n_d = 1'b1;
        cs_dec_n_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      key_bits <= '0;
      data_sr  <= '0;
      key_sr   <= '0;
      rx_sr    <= '0;
      sel_dec  <= 1'b0;
      prio_dec <= 1'b0;
      result   <= '0;
      mosi     <= 1'b0;
      cs_enc_n <= 1'b1;
      cs_dec_n <= 1'b1;
      busy     <= 1'b0;
      gnt_enc  <= 1'b0;
      gnt_dec  <= 1'b0;
      done_enc <= 1'b0;
      done_dec <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      key_bits <= key_bits_d;
      data_sr  <= data_sr_d;
      key_sr   <= key_sr_d;
      rx_sr    <= rx_sr_d;
      sel_dec  <= sel_dec_d;
      prio_dec <= prio_dec_d;
      result   <= result_d;
      mosi     <= mosi_d;
      cs_enc_n <= cs_enc_n_d;
      cs_dec_n <= cs_dec_n_d;
      busy     <= busy_d;
      gnt_enc  <= gnt_enc_d;
      gnt_dec  <= gnt_dec_d;
      done_enc <= done_enc_d;
      done_dec <= done_dec_d;
    end
  end

endmodule
